// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise ops to WIDTH-bit operands.
// Optional S2 parity output is built when LU_PARITY_EN is defined.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_cnt
`ifdef LU_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic             s2_zero_q, s2_zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_ready, s2_ready;
  logic             in_fire, s2_load, out_fire;
  logic [WIDTH-1:0] f_y;

  // Ready chain is purely combinational back from out_ready.
  assign s2_ready = ~s2_v_q | out_ready;
  assign s1_ready = ~s1_v_q | s2_ready;
  assign in_ready = s1_ready;

  assign in_fire  = in_valid & s1_ready;
  assign s2_load  = s1_v_q & s2_ready;
  assign out_fire = s2_v_q & out_ready;

  always_comb begin
    f_y = '0;
    unique case (s1_op_q)
      3'd0: f_y = s1_a_q & s1_b_q;
      3'd1: f_y = s1_a_q | s1_b_q;
      3'd2: f_y = ~s1_a_q;
      3'd3: f_y = ~(s1_a_q | s1_b_q);
      3'd4: f_y = s1_a_q ^ s1_b_q;
      3'd5: f_y = ~(s1_a_q ^ s1_b_q);
      3'd6: f_y = ~(s1_a_q & s1_b_q);
      3'd7: f_y = s1_b_q;
      default: f_y = '0;
    endcase
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_op_d = s1_op_q;
    if (in_fire) begin
      s1_v_d  = 1'b1;
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      s1_op_d = in_op;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_y_d    = s2_y_q;
    s2_zero_d = s2_zero_q;
    if (s2_load) begin
      s2_v_d    = 1'b1;
      s2_y_d    = f_y;
      s2_zero_d = ~|f_y;
    end else if (out_fire) begin
      s2_v_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_op_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_y_q    <= '0;
      s2_zero_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_op_q   <= s1_op_d;
      s2_v_q    <= s2_v_d;
      s2_y_q    <= s2_y_d;
      s2_zero_q <= s2_zero_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef LU_PARITY_EN
  logic s2_par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_par_q <= 1'b0;
    end else if (s2_load) begin
      s2_par_q <= ^f_y;
    end
  end

  assign out_par = s2_par_q;
`endif

  assign out_valid = s2_v_q;
  assign out_y     = s2_y_q;
  assign out_zero  = s2_zero_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized and directed bench for logic_unit_pipe, checked against a truth-table queue model.
// A second instance with CNT_W=2 exercises counter saturation on the same traffic.
module tb_logic_unit_pipe;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;

  logic         in_ready, out_valid, out_zero;
  logic [W-1:0] out_y;
  logic [15:0]  out_cnt;

  logic         in_ready_s, out_valid_s, out_zero_s;
  logic [W-1:0] out_y_s;
  logic [1:0]   out_cnt_s;
`ifdef LU_PARITY_EN
  logic         out_par, out_par_s;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_cnt   (out_cnt)
`ifdef LU_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_y     (out_y_s),
    .out_zero  (out_zero_s),
    .out_cnt   (out_cnt_s)
`ifdef LU_PARITY_EN
    ,
    .out_par   (out_par_s)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-bit truth table, indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] y;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0011;
      3'd3: tt = 4'b0001;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0111;
      default: tt = 4'b1010;
    endcase
    for (int i = 0; i < int'(W); i++) y[i] = tt[{a[i], b[i]}];
    return y;
  endfunction

  typedef struct {
    logic [W-1:0] y;
    int           cyc;
  } item_t;

  item_t        q[$];
  int           cyc = 0;
  int           delivered = 0;
  int           n_acc = 0;
  bit           lat_chk = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_y = '0;

  // Observe handshakes half a cycle before the edge that commits them.
  always @(negedge clk) begin
    item_t it;
    cyc++;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      delivered  = 0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_y", out_y, prev_y);
      end
      check_eq("cnt", out_cnt, delivered);
      check_eq("cnt_sat", out_cnt_s, (delivered > 3) ? 3 : delivered);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", 1, 0);
        end else begin
          it = q.pop_front();
          check_eq("y", out_y, it.y);
          check_eq("zero", out_zero, (it.y == 0));
          check_eq("sat_valid", out_valid_s, 1);
          check_eq("sat_y", out_y_s, it.y);
`ifdef LU_PARITY_EN
          check_eq("par", out_par, ^it.y);
`endif
          if (lat_chk) check_eq("latency", cyc - it.cyc, 2);
        end
        delivered++;
      end
      if (in_valid && in_ready) begin
        it.y   = ref_op(in_op, in_a, in_b);
        it.cyc = cyc;
        q.push_back(it);
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", q.size(), 0);
  endtask

  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_y", out_y, 0);
    check_eq("rst_zero", out_zero, 1);
    check_eq("rst_cnt", out_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_in_ready_sat", in_ready_s, 1);
`ifdef LU_PARITY_EN
    check_eq("rst_par", out_par, 0);
`endif
    @(posedge clk);
    #1;

    // All eight ops back to back, full throughput
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int op = 0; op < 8; op++) send(8'hF0, 8'h3C, op[2:0]);
    send(8'hA5, 8'hA5, 3'd4);
`ifdef LU_PARITY_EN
    send(8'h01, 8'h00, 3'd1);
`endif
    drain();
    lat_chk = 1'b0;
    check_eq("delivered_dir", delivered, 9
`ifdef LU_PARITY_EN
             + 1
`endif
             );

    // Backpressure: two accepts fill both stages, third waits
    out_ready = 1'b0;
    base = n_acc;
    send(8'h12, 8'h34, 3'd0);
    send(8'h56, 8'h78, 3'd1);
    in_valid = 1'b1;
    in_a     = 8'h9A;
    in_b     = 8'hBC;
    in_op    = 3'd4;
    repeat (4) begin
      @(negedge clk);
      check_eq("stall_in_ready", in_ready, 0);
    end
    check_eq("stall_accepts", n_acc - base, 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h9A, 8'hBC, 3'd4);
    drain();
    check_eq("bp_accepts", n_acc - base, 3);

    // Reset while both stages are full and stalled
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd5);
    send(8'h33, 8'h44, 3'd6);
    @(posedge clk);
    #1;
    pulse_reset(1);
    @(negedge clk);
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_cnt", out_cnt, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_op     = 3'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();
    check_eq("final_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
